// File: rtl/dsp_pkg.sv
// dsp_pkg: shared frame geometry defaults, sample type, FSM states and the Q2.14 gain/saturate helper
package dsp_pkg;
    localparam int DEF_FRAME_LEN = 256;
    localparam int DEF_HOP = 128;
    localparam int DEF_GAIN_Q14 = 15170;
    typedef logic signed [15:0] sample_t;
    typedef enum logic [1:0] {IDLE, HEAD, TAIL, FLUSH} state_t;
    function automatic sample_t sat_gain(input logic signed [16:0] s, input logic [15:0] g);
        logic signed [33:0] p;
        logic signed [33:0] q;
        p = 34'(s) * 34'($signed({1'b0, g}));
        q = p >>> 14;
        return q > 34'sd32767 ? 16'sh7fff : q < -34'sd32768 ? 16'sh8000 : q[15:0];
    endfunction
endpackage

// File: rtl/tail_ram.sv
// tail_ram: HOP-deep store for the second half of the previous frame; synchronous write, combinational read
module tail_ram
    import dsp_pkg::*;
#(
    parameter int DEPTH = DEF_HOP,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  sample_t       wdata,
    input  logic [AW-1:0] raddr,
    output sample_t       rdata
);
    sample_t mem [DEPTH];
    always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/overlap_add.sv
// overlap_add: 50% overlap-add of windowed frames with gain normalisation, saturation and tail flush
module overlap_add
    import dsp_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int HOP = DEF_HOP,
    parameter int GAIN_Q14 = DEF_GAIN_Q14
) (
    input  logic    clk,
    input  logic    reset,
    input  sample_t in,
    input  logic    in_valid,
    input  logic    in_first,
    output logic    in_ready,
    input  logic    flush,
    output sample_t out,
    output logic    out_valid,
    output logic    frame_err
);
    localparam int IW = $clog2(FRAME_LEN);
    localparam int AW = HOP > 1 ? $clog2(HOP) : 1;
    localparam logic [15:0] GAIN = 16'(GAIN_Q14);
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, k;
    logic tail_valid_q, tail_valid_d, flush_pend_q, flush_pend_d;
    logic out_valid_q, out_valid_d, frame_err_q, frame_err_d;
    sample_t out_q, out_d, tail_rd, tail_term;
    logic acc, err, go_flush, we;
    logic [AW-1:0] raddr, waddr;

    tail_ram #(.DEPTH(HOP)) u_tail (
        .clk(clk), .we(we), .waddr(waddr), .wdata(in), .raddr(raddr), .rdata(tail_rd)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            tail_valid_q <= 1'b0;
            flush_pend_q <= 1'b0;
            out_q <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            tail_valid_q <= tail_valid_d;
            flush_pend_q <= flush_pend_d;
            out_q <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // A resync (in_first off boundary) restarts the frame on the current sample as index 0.
    always_comb begin
        go_flush = (flush_pend_q || flush) && idx_q == '0 && (state_q == IDLE || state_q == HEAD);
        in_ready = state_q != FLUSH && !go_flush;
        acc = in_valid && in_ready;
        err = acc && in_first && idx_q != '0;
        k = err ? '0 : idx_q;
        we = acc && !err && state_q == TAIL;
        raddr = k[AW-1:0];
        waddr = AW'(idx_q - IW'(HOP));
        tail_term = tail_valid_q ? tail_rd : '0;
    end

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        tail_valid_d = tail_valid_q;
        flush_pend_d = flush_pend_q || flush;
        out_d = out_q;
        out_valid_d = 1'b0;
        frame_err_d = err;
        if (go_flush) begin
            state_d = FLUSH;
            idx_d = '0;
            flush_pend_d = 1'b0;
        end else if (state_q == FLUSH) begin
            out_d = sat_gain(17'(tail_term), GAIN);
            out_valid_d = 1'b1;
            idx_d = idx_q == IW'(HOP - 1) ? '0 : idx_q + 1'b1;
            state_d = idx_q == IW'(HOP - 1) ? IDLE : FLUSH;
            tail_valid_d = tail_valid_q && idx_q != IW'(HOP - 1);
        end else if (acc && (state_q != TAIL || err)) begin
            out_d = sat_gain(17'(in) + 17'(tail_term), GAIN);
            out_valid_d = 1'b1;
            idx_d = k + 1'b1;
            state_d = k == IW'(HOP - 1) ? TAIL : HEAD;
        end else if (acc) begin
            idx_d = idx_q == IW'(FRAME_LEN - 1) ? '0 : idx_q + 1'b1;
            state_d = idx_q == IW'(FRAME_LEN - 1) ? HEAD : TAIL;
            tail_valid_d = tail_valid_q || idx_q == IW'(FRAME_LEN - 1);
        end
    end

    assign out = out_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
endmodule
